// File: rtl/riscboy_ppu_tile_texel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : riscboy_ppu_tile_texel_fetch
// Brief    : PPU texel fetch stage. Turns tile-info records (u, v, tile
//            number, discard) into tileset halfword reads, issues them in
//            order, and extracts one zero-extended texel per record.
// Options  : RISCBOY_PPU_TEXEL_REUSE_EN - skip the bus read when a record
//            hits the same halfword as the most recent fetch.
// Revision : 1.0 - initial release
// ============================================================================
module riscboy_ppu_tile_texel_fetch #(
    parameter int                W_ADDR      = 18,
    parameter int                W_DATA      = 16,
    parameter logic [W_ADDR-1:0] ADDR_MASK   = {W_ADDR{1'b1}},
    parameter int                W_TILE_NUM  = 8,
    parameter int                W_SPAN_TYPE = 3,
    parameter int                QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  span_start,
    input  logic [W_ADDR-1:0]     span_tileset_ptr,
    input  logic [2:0]            span_log_bpp,
    input  logic                  span_tilesize,

    input  logic [3:0]            tinfo_u,
    input  logic [3:0]            tinfo_v,
    input  logic [W_TILE_NUM-1:0] tinfo_tilenum,
    input  logic                  tinfo_discard,
    input  logic                  tinfo_vld,
    output logic                  tinfo_rdy,

    output logic                  bus_addr_vld,
    input  logic                  bus_addr_rdy,
    output logic [W_ADDR-1:0]     bus_addr,
    input  logic                  bus_data_vld,
    input  logic [W_DATA-1:0]     bus_data,

    output logic [15:0]           pixel_data,
    output logic                  pixel_discard,
    output logic                  pixel_vld,
    input  logic                  pixel_rdy,

    output logic                  busy
);

    localparam int W_PTR = $clog2(QUEUE_DEPTH);

    // Elaboration-time guard on the parameter set this block supports.
    generate
        if (W_DATA != 16 || QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0
            || W_SPAN_TYPE < 1) begin : g_param_check
            $error("riscboy_ppu_tile_texel_fetch: unsupported parameter set");
        end
    endgenerate

    typedef struct packed {
        logic       discard;
        logic       reuse;
        logic [3:0] shift;
        logic [2:0] log_bpp;
    } rec_t;

    // ------------------------------------------------------------------------
    // Span configuration
    // ------------------------------------------------------------------------
    logic [W_ADDR-1:0] cfg_ptr;
    logic [2:0]        cfg_log_bpp;
    logic              cfg_tilesize;
    logic [2:0]        span_log_bpp_clamped;

    // Anything above 16 bpp is treated as 16 bpp.
    assign span_log_bpp_clamped = (span_log_bpp > 3'd4) ? 3'd4 : span_log_bpp;

    // Latch the span configuration on span_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ptr      <= '0;
            cfg_log_bpp  <= 3'd0;
            cfg_tilesize <= 1'b0;
        end else if (span_start) begin
            cfg_ptr      <= span_tileset_ptr & ADDR_MASK;
            cfg_log_bpp  <= span_log_bpp_clamped;
            cfg_tilesize <= span_tilesize;
        end
    end

    // ------------------------------------------------------------------------
    // Address arithmetic
    // ------------------------------------------------------------------------
    logic [15:0]       tilenum_ext;
    logic [15:0]       texel_idx;
    logic [19:0]       bit_off;
    logic [W_ADDR-1:0] fetch_addr;

    // Texel index within the tileset, then bit offset and halfword address.
    always_comb begin
        tilenum_ext = 16'(tinfo_tilenum);
        if (cfg_tilesize) begin
            texel_idx = (tilenum_ext << 8) + {8'h00, tinfo_v, tinfo_u};
        end else begin
            texel_idx = (tilenum_ext << 6) + {10'h000, tinfo_v[2:0], tinfo_u[2:0]};
        end
        bit_off    = {4'h0, texel_idx} << cfg_log_bpp;
        fetch_addr = (cfg_ptr + W_ADDR'(bit_off[19:4])) & ADDR_MASK;
    end

    assign bus_addr = fetch_addr;

    // ------------------------------------------------------------------------
    // Queue storage and pointers
    // ------------------------------------------------------------------------
    rec_t              rec_mem [QUEUE_DEPTH];
    logic [W_PTR:0]    rec_wr_ptr;
    logic [W_PTR:0]    rec_rd_ptr;
    logic              rec_empty;
    logic              rec_full;
    logic              rec_push;
    logic              rec_pop;
    rec_t              rec_new;
    rec_t              rec_head;

    logic [W_DATA-1:0] data_mem [QUEUE_DEPTH];
    logic [W_PTR:0]    data_wr_ptr;
    logic [W_PTR:0]    data_rd_ptr;
    logic              data_empty;
    logic              data_pop;
    logic [W_DATA-1:0] data_head;

    logic [W_PTR:0]    outstanding;
    logic              issue_fire;
    logic              issue_skip;
    logic              reuse_hit;
    logic [W_DATA-1:0] texel_src;

    assign rec_empty  = (rec_wr_ptr == rec_rd_ptr);
    assign rec_full   = (rec_wr_ptr == {~rec_rd_ptr[W_PTR], rec_rd_ptr[W_PTR-1:0]});
    assign data_empty = (data_wr_ptr == data_rd_ptr);
    assign rec_head   = rec_mem[rec_rd_ptr[W_PTR-1:0]];
    assign data_head  = data_mem[data_rd_ptr[W_PTR-1:0]];

    // ------------------------------------------------------------------------
    // Halfword reuse
    // ------------------------------------------------------------------------
`ifdef RISCBOY_PPU_TEXEL_REUSE_EN
    logic [W_ADDR-1:0] last_addr;
    logic              reuse_vld;
    logic [W_DATA-1:0] last_data;

    // Remember the most recently issued fetch address; a new span forgets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr <= '0;
            reuse_vld <= 1'b0;
        end else if (span_start) begin
            reuse_vld <= 1'b0;
        end else if (issue_fire) begin
            last_addr <= fetch_addr;
            reuse_vld <= 1'b1;
        end
    end

    // Capture each popped fetch word; reuse records follow their fetch in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_data <= '0;
        end else if (data_pop) begin
            last_data <= data_head;
        end
    end

    assign reuse_hit = reuse_vld && (fetch_addr == last_addr);
    assign texel_src = rec_head.reuse ? last_data : data_head;
`else
    assign reuse_hit = 1'b0;
    assign texel_src = data_head;
`endif

    // ------------------------------------------------------------------------
    // Issue handshake
    // ------------------------------------------------------------------------
    // Records that need no bus read only wait for queue space.
    always_comb begin
        issue_skip   = tinfo_discard || reuse_hit;
        bus_addr_vld = tinfo_vld && !issue_skip && !rec_full;
        tinfo_rdy    = issue_skip ? (tinfo_vld && !rec_full)
                                  : (bus_addr_vld && bus_addr_rdy);
        issue_fire   = bus_addr_vld && bus_addr_rdy;
        rec_push     = tinfo_vld && tinfo_rdy;
        rec_new      = '{discard: tinfo_discard,
                         reuse:   reuse_hit && !tinfo_discard,
                         shift:   bit_off[3:0],
                         log_bpp: cfg_log_bpp};
    end

    // Record queue pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_wr_ptr <= '0;
            rec_rd_ptr <= '0;
        end else begin
            if (rec_push) rec_wr_ptr <= rec_wr_ptr + (W_PTR + 1)'(1);
            if (rec_pop)  rec_rd_ptr <= rec_rd_ptr + (W_PTR + 1)'(1);
        end
    end

    // Record queue storage.
    always_ff @(posedge clk) begin
        if (rec_push) rec_mem[rec_wr_ptr[W_PTR-1:0]] <= rec_new;
    end

    // Data FIFO pointers; read data arrives in issue order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_wr_ptr <= '0;
            data_rd_ptr <= '0;
        end else begin
            if (bus_data_vld) data_wr_ptr <= data_wr_ptr + (W_PTR + 1)'(1);
            if (data_pop)     data_rd_ptr <= data_rd_ptr + (W_PTR + 1)'(1);
        end
    end

    // Data FIFO storage.
    always_ff @(posedge clk) begin
        if (bus_data_vld) data_mem[data_wr_ptr[W_PTR-1:0]] <= bus_data;
    end

    // Count of bus reads issued whose data has not yet returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({issue_fire, bus_data_vld})
                2'b10:   outstanding <= outstanding + (W_PTR + 1)'(1);
                2'b01:   outstanding <= outstanding - (W_PTR + 1)'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Pixel output
    // ------------------------------------------------------------------------
    logic [15:0] texel_shifted;
    logic [15:0] texel_mask;

    // Head record completes once its source word is available.
    always_comb begin
        pixel_vld     = !rec_empty && (rec_head.discard || rec_head.reuse || !data_empty);
        rec_pop       = pixel_vld && pixel_rdy;
        data_pop      = rec_pop && !rec_head.discard && !rec_head.reuse;
        texel_shifted = 16'(texel_src) >> rec_head.shift;
        case (rec_head.log_bpp)
            3'd0:    texel_mask = 16'h0001;
            3'd1:    texel_mask = 16'h0003;
            3'd2:    texel_mask = 16'h000f;
            3'd3:    texel_mask = 16'h00ff;
            default: texel_mask = 16'hffff;
        endcase
        pixel_data    = (pixel_vld && !rec_head.discard) ? (texel_shifted & texel_mask) : 16'h0000;
        pixel_discard = pixel_vld && rec_head.discard;
        busy          = !rec_empty || (outstanding != '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_riscboy_ppu_tile_texel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscboy_ppu_tile_texel_fetch
// Brief    : Scoreboard bench for the texel fetch stage. Expected pixels are
//            computed from a tileset memory model when each record is
//            accepted; a monitor compares every emitted pixel in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscboy_ppu_tile_texel_fetch;

    logic        clk;
    logic        rst_n;
    logic        span_start;
    logic [17:0] span_tileset_ptr;
    logic [2:0]  span_log_bpp;
    logic        span_tilesize;
    logic [3:0]  tinfo_u;
    logic [3:0]  tinfo_v;
    logic [7:0]  tinfo_tilenum;
    logic        tinfo_discard;
    logic        tinfo_vld;
    logic        tinfo_rdy;
    logic        bus_addr_vld;
    logic        bus_addr_rdy;
    logic [17:0] bus_addr;
    logic        bus_data_vld;
    logic [15:0] bus_data;
    logic [15:0] pixel_data;
    logic        pixel_discard;
    logic        pixel_vld;
    logic        pixel_rdy;
    logic        busy;

    riscboy_ppu_tile_texel_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .span_start       (span_start),
        .span_tileset_ptr (span_tileset_ptr),
        .span_log_bpp     (span_log_bpp),
        .span_tilesize    (span_tilesize),
        .tinfo_u          (tinfo_u),
        .tinfo_v          (tinfo_v),
        .tinfo_tilenum    (tinfo_tilenum),
        .tinfo_discard    (tinfo_discard),
        .tinfo_vld        (tinfo_vld),
        .tinfo_rdy        (tinfo_rdy),
        .bus_addr_vld     (bus_addr_vld),
        .bus_addr_rdy     (bus_addr_rdy),
        .bus_addr         (bus_addr),
        .bus_data_vld     (bus_data_vld),
        .bus_data         (bus_data),
        .pixel_data       (pixel_data),
        .pixel_discard    (pixel_discard),
        .pixel_vld        (pixel_vld),
        .pixel_rdy        (pixel_rdy),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // ---------------- reference model ----------------
    int m_ptr = 0;
    int m_lb  = 0;
    int m_ts  = 0;
    int mem_ovr [int];

    function automatic int mem_rd(int a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return ((a * 40503) ^ (a >> 5) ^ 32'h5a5a) & 32'hffff;
    endfunction

    function automatic int model_bits(int tn, int u, int v);
        int t;
        if (m_ts != 0) t = tn * 256 + v * 16 + u;
        else           t = tn * 64 + (v % 8) * 8 + (u % 8);
        t = t % 65536;
        return t * (1 << m_lb);
    endfunction

    function automatic int model_addr(int tn, int u, int v);
        return (m_ptr + model_bits(tn, u, v) / 16) % 262144;
    endfunction

    function automatic int model_pixel(int tn, int u, int v);
        int bits;
        bits = model_bits(tn, u, v);
        return (mem_rd(model_addr(tn, u, v)) >> (bits % 16)) % (1 << (1 << m_lb));
    endfunction

    // ---------------- scoreboard and logs ----------------
    int exp_disc [$];
    int exp_data [$];
    int pix_data_log [$];
    int pix_disc_log [$];
    int issued [$];
    int pend_addr [$];
    int pend_due [$];

    // ---------------- environment ----------------
    int cycle     = 0;
    int prdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    int ardy_mode = 0;   // 0: always ready, 1: random
    int dly_min   = 1;
    int dly_max   = 1;

    // Bus slave, pixel sink ready and in-order read return.
    initial begin
        bus_addr_rdy = 1'b0;
        bus_data_vld = 1'b0;
        bus_data     = 16'h0;
        pixel_rdy    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            bus_addr_rdy = (ardy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            case (prdy_mode)
                0:       pixel_rdy = 1'b1;
                1:       pixel_rdy = ($urandom_range(0, 3) != 0);
                default: pixel_rdy = 1'b0;
            endcase
            if (pend_addr.size() > 0 && pend_due[0] <= cycle) begin
                bus_data_vld = 1'b1;
                bus_data     = 16'(mem_rd(pend_addr[0]));
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                bus_data_vld = 1'b0;
                bus_data     = 16'($urandom);
            end
        end
    end

    // Capture accepted bus requests.
    always @(negedge clk) begin
        if (rst_n && bus_addr_vld && bus_addr_rdy) begin
            issued.push_back(int'(bus_addr));
            pend_addr.push_back(int'(bus_addr));
            pend_due.push_back(cycle + int'($urandom_range(dly_min, dly_max)));
        end
    end

    // Pixel monitor: compare each accepted pixel with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && pixel_vld && pixel_rdy) begin
            pix_data_log.push_back(int'(pixel_data));
            pix_disc_log.push_back(int'(pixel_discard));
            if (exp_disc.size() == 0) begin
                check("pixel_unexpected", exp_disc.size(), 1);
            end else begin
                check("pixel_discard", int'(pixel_discard), exp_disc[0]);
                check("pixel_data", int'(pixel_data), exp_data[0]);
                void'(exp_disc.pop_front());
                void'(exp_data.pop_front());
            end
        end
    end

    // ---------------- stimulus tasks (called at posedge + 1) ----------------
    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_disc.size() != 0 || pend_addr.size() != 0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) check("idle_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_span(int ptr, int lb, int ts);
        wait_idle();
        span_start       = 1'b1;
        span_tileset_ptr = 18'(ptr);
        span_log_bpp     = 3'(lb);
        span_tilesize    = ts[0];
        @(posedge clk);
        #1;
        span_start = 1'b0;
        m_ptr = ptr & 32'h3ffff;
        m_lb  = (lb > 4) ? 4 : lb;
        m_ts  = ts;
    endtask

    task automatic send_rec(int u, int v, int tn, int disc);
        int n = 0;
        tinfo_u       = 4'(u);
        tinfo_v       = 4'(v);
        tinfo_tilenum = 8'(tn);
        tinfo_discard = disc[0];
        tinfo_vld     = 1'b1;
        forever begin
            @(negedge clk);
            if (tinfo_rdy) begin
                exp_disc.push_back(disc);
                exp_data.push_back(disc != 0 ? 0 : model_pixel(tn, u, v));
                break;
            end
            n++;
            if (n > 500) begin
                check("tinfo_accept_timeout", n, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        tinfo_vld = 1'b0;
    endtask

    task automatic clear_logs();
        issued.delete();
        pix_data_log.delete();
        pix_disc_log.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, got %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int t5_done = 0;
    int exp4 [3] = '{0, 1, 0};

    initial begin
        rst_n = 1'b0;
        span_start = 1'b0;
        span_tileset_ptr = '0;
        span_log_bpp = '0;
        span_tilesize = 1'b0;
        tinfo_u = '0;
        tinfo_v = '0;
        tinfo_tilenum = '0;
        tinfo_discard = 1'b0;
        tinfo_vld = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tinfo_rdy", int'(tinfo_rdy), 0);
        check("reset_bus_addr_vld", int'(bus_addr_vld), 0);
        check("reset_pixel_vld", int'(pixel_vld), 0);
        check("reset_pixel_discard", int'(pixel_discard), 0);
        check("reset_pixel_data", int'(pixel_data), 0);
        check("reset_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4bpp, 8px tiles: tile 3, (5,2) -> 0x1035, nibble 1 of 0xABCD.
        mem_ovr[32'h1035] = 32'habcd;
        set_span(32'h1000, 2, 0);
        clear_logs();
        send_rec(5, 2, 3, 0);
        wait_idle();
        check("t1_req_count", issued.size(), 1);
        if (issued.size() > 0) check("t1_bus_addr", issued[0], 32'h1035);
        if (pix_data_log.size() > 0) check("t1_pixel", pix_data_log[0], 32'h000c);

        // 16bpp, 16px tiles: tile 1, (15,15) -> 0x01FF, whole word.
        mem_ovr[32'h01ff] = 32'h1234;
        set_span(0, 4, 1);
        clear_logs();
        send_rec(15, 15, 1, 0);
        wait_idle();
        if (issued.size() > 0) check("t2_bus_addr", issued[0], 32'h01ff);
        if (pix_data_log.size() > 0) check("t2_pixel", pix_data_log[0], 32'h1234);

        // 1bpp at the top of the address space, then a tile that wraps to 0x00003.
        mem_ovr[32'h3ffff] = 32'h0080;
        set_span(32'h3ffff, 0, 0);
        clear_logs();
        send_rec(7, 0, 0, 0);
        send_rec(0, 0, 1, 0);
        wait_idle();
        check("t3_req_count", issued.size(), 2);
        if (issued.size() > 1) begin
            check("t3_bus_addr_top", issued[0], 32'h3ffff);
            check("t3_bus_addr_wrap", issued[1], 32'h00003);
        end
        if (pix_data_log.size() > 0) check("t3_pixel", pix_data_log[0], 1);

        // fetch, discard, fetch with slow read data: order must hold.
        set_span(32'h0400, 3, 0);
        dly_min = 5;
        dly_max = 5;
        clear_logs();
        send_rec(1, 1, 2, 0);
        send_rec(2, 2, 2, 1);
        send_rec(3, 3, 2, 0);
        wait_idle();
        check("t4_pixel_count", pix_disc_log.size(), 3);
        for (int k = 0; k < 3 && k < pix_disc_log.size(); k++)
            check($sformatf("t4_discard_order_%0d", k), pix_disc_log[k], exp4[k]);

        // Sink stalled: only QUEUE_DEPTH records may be in flight.
        set_span(32'h0100, 4, 0);
        dly_min = 1;
        dly_max = 3;
        prdy_mode = 2;
        clear_logs();
        fork
            begin
                for (int i = 0; i < 6; i++) send_rec(i, 0, 0, 0);
                t5_done = 1;
            end
        join_none
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("t5_req_count_stalled", issued.size(), 4);
        check("t5_tinfo_rdy_stalled", int'(tinfo_rdy), 0);
        check("t5_bus_addr_vld_stalled", int'(bus_addr_vld), 0);
        check("t5_busy_stalled", int'(busy), 1);
        check("t5_pixel_vld_stalled", int'(pixel_vld), 1);
        @(posedge clk);
        #1;
        prdy_mode = 0;
        for (int n = 0; n < 300 && t5_done == 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("t5_sender_done", t5_done, 1);
        wait_idle();
        check("t5_req_count_final", issued.size(), 6);
        check("t5_pixel_count", pix_data_log.size(), 6);

        // Four 4bpp texels sharing one halfword.
        mem_ovr[32'h2050] = 32'h4321;
        set_span(32'h2000, 2, 0);
        clear_logs();
        for (int i = 0; i < 4; i++) send_rec(i, 0, 5, 0);
        wait_idle();
`ifdef RISCBOY_PPU_TEXEL_REUSE_EN
        check("t6_req_count", issued.size(), 1);
`else
        check("t6_req_count", issued.size(), 4);
`endif
        for (int i = 0; i < 4 && i < pix_data_log.size(); i++)
            check($sformatf("t6_nibble_%0d", i), pix_data_log[i], i + 1);

        // Randomized records, configs, backpressure and read latency.
        ardy_mode = 1;
        prdy_mode = 1;
        dly_min = 1;
        dly_max = 6;
        for (int s = 0; s < 6; s++) begin
            set_span(int'($urandom_range(0, 32'h3ffff)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 1)));
            for (int r = 0; r < 50; r++) begin
                int gap;
                send_rec(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                         (s % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255)),
                         ($urandom_range(0, 4) == 0) ? 1 : 0);
                gap = int'($urandom_range(0, 2));
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        prdy_mode = 0;
        wait_idle();
        check("final_scoreboard_empty", exp_disc.size(), 0);
        @(negedge clk);
        check("final_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
